// File: rtl/flash_prog_sequencer.sv
// flash_prog_sequencer: drives the SPI command engine through one complete
// single-byte program (WREN, WEL check, write, busy polling, optional verify).
module flash_prog_sequencer #(
    parameter int unsigned EN_CYCLES = 4,
    parameter int unsigned POLL_GAP  = 16,
    parameter int unsigned POLL_MAX  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       verify,
    input  logic [7:0] wr_byte,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic       eng_enable,
    output logic [2:0] eng_controll,
    output logic [7:0] eng_wdata,
    input  logic       eng_done,
    input  logic [7:0] eng_status,
    input  logic [7:0] eng_rdata
);

    localparam int unsigned TMR_W  = 8;
    localparam int unsigned PCNT_W = 16;

    localparam logic [TMR_W-1:0]  EN_LAST  = TMR_W'(EN_CYCLES - 1);
    localparam logic [TMR_W-1:0]  GAP_LAST = TMR_W'(POLL_GAP - 1);
    localparam logic [PCNT_W-1:0] POLL_LIM = PCNT_W'(POLL_MAX);

    localparam logic [2:0] OP_IDLE      = 3'b000;
    localparam logic [2:0] OP_WRITE_CMD = 3'b001;
    localparam logic [2:0] OP_RD_STATUS = 3'b010;
    localparam logic [2:0] OP_WR_DATA   = 3'b011;
    localparam logic [2:0] OP_RD_DATA   = 3'b100;

    localparam logic [1:0] ERR_WEL     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_VERIFY  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WREN_ISS,
        S_WREN_WT,
        S_CHK_ISS,
        S_CHK_WT,
        S_PROG_ISS,
        S_PROG_WT,
        S_POLL_ISS,
        S_POLL_WT,
        S_GAP,
        S_READ_ISS,
        S_READ_WT,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [PCNT_W-1:0]  poll_q, poll_d;
    logic [PCNT_W-1:0]  poll_inc;
    logic               verify_q, verify_d;
    logic               fail_q, fail_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               en_q, en_d;
    logic [2:0]         ctrl_q, ctrl_d;

    // Only WIP and WEL carry meaning for this sequencer.
    logic unused_status;
    assign unused_status = ^eng_status[7:2];

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            poll_q     <= '0;
            verify_q   <= 1'b0;
            fail_q     <= 1'b0;
            wdata_q    <= '0;
            err_code_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            en_q       <= 1'b0;
            ctrl_q     <= OP_IDLE;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            poll_q     <= poll_d;
            verify_q   <= verify_d;
            fail_q     <= fail_d;
            wdata_q    <= wdata_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            en_q       <= en_d;
            ctrl_q     <= ctrl_d;
        end
    end

    // Next-state sequencing and registered output decode of the current state.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        poll_d     = poll_q;
        verify_d   = verify_q;
        fail_d     = fail_q;
        wdata_d    = wdata_q;
        err_code_d = err_code_q;
        poll_inc   = poll_q + PCNT_W'(1);

        busy_d  = (state_q != S_IDLE) && (state_q != S_FIN);
        done_d  = (state_q == S_FIN) && !fail_q;
        error_d = (state_q == S_FIN) && fail_q;
        en_d    = 1'b0;
        ctrl_d  = OP_IDLE;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    verify_d   = verify;
                    wdata_d    = wr_byte;
                    err_code_d = 2'b00;
                    fail_d     = 1'b0;
                    tmr_d      = '0;
                    state_d    = S_WREN_ISS;
                end
            end
            S_WREN_ISS: begin
                en_d   = 1'b1;
                ctrl_d = OP_WRITE_CMD;
                if (tmr_q == EN_LAST) begin
                    tmr_d   = '0;
                    state_d = S_WREN_WT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_WREN_WT: begin
                ctrl_d = OP_WRITE_CMD;
                if (eng_done) state_d = S_CHK_ISS;
            end
            S_CHK_ISS: begin
                en_d   = 1'b1;
                ctrl_d = OP_RD_STATUS;
                if (tmr_q == EN_LAST) begin
                    tmr_d   = '0;
                    state_d = S_CHK_WT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_CHK_WT: begin
                ctrl_d = OP_RD_STATUS;
                if (eng_done) begin
                    if (eng_status[1]) begin
                        state_d = S_PROG_ISS;
                    end else begin
                        err_code_d = ERR_WEL;
                        fail_d     = 1'b1;
                        state_d    = S_FIN;
                    end
                end
            end
            S_PROG_ISS: begin
                en_d   = 1'b1;
                ctrl_d = OP_WR_DATA;
                if (tmr_q == EN_LAST) begin
                    tmr_d   = '0;
                    state_d = S_PROG_WT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_PROG_WT: begin
                ctrl_d = OP_WR_DATA;
                if (eng_done) begin
                    poll_d  = '0;
                    state_d = S_POLL_ISS;
                end
            end
            S_POLL_ISS: begin
                en_d   = 1'b1;
                ctrl_d = OP_RD_STATUS;
                if (tmr_q == EN_LAST) begin
                    tmr_d   = '0;
                    state_d = S_POLL_WT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_POLL_WT: begin
                ctrl_d = OP_RD_STATUS;
                if (eng_done) begin
                    poll_d = poll_inc;
                    if (!eng_status[0]) begin
                        state_d = verify_q ? S_READ_ISS : S_FIN;
                    end else if (poll_inc == POLL_LIM) begin
                        err_code_d = ERR_TIMEOUT;
                        fail_d     = 1'b1;
                        state_d    = S_FIN;
                    end else begin
                        tmr_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (tmr_q == GAP_LAST) begin
                    tmr_d   = '0;
                    state_d = S_POLL_ISS;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_READ_ISS: begin
                en_d   = 1'b1;
                ctrl_d = OP_RD_DATA;
                if (tmr_q == EN_LAST) begin
                    tmr_d   = '0;
                    state_d = S_READ_WT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_READ_WT: begin
                ctrl_d = OP_RD_DATA;
                if (eng_done) begin
                    if (eng_rdata == wdata_q) begin
                        state_d = S_FIN;
                    end else begin
                        err_code_d = ERR_VERIFY;
                        fail_d     = 1'b1;
                        state_d    = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign eng_enable   = en_q;
    assign eng_controll = ctrl_q;
    assign eng_wdata    = wdata_q;

endmodule

// File: tb/tb_flash_prog_sequencer.sv
// Self-checking bench for flash_prog_sequencer with a randomized engine model.
module tb_flash_prog_sequencer;

    localparam int unsigned EN_CYC = 4;
    localparam int unsigned GAP    = 5;
    localparam int unsigned PMAX   = 3;

    localparam logic [2:0] OP_WRITE_CMD = 3'b001;
    localparam logic [2:0] OP_RD_STATUS = 3'b010;
    localparam logic [2:0] OP_WR_DATA   = 3'b011;
    localparam logic [2:0] OP_RD_DATA   = 3'b100;

    logic       clk;
    logic       rst;
    logic       start;
    logic       verify;
    logic [7:0] wr_byte;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic       eng_enable;
    logic [2:0] eng_controll;
    logic [7:0] eng_wdata;
    logic       eng_done;
    logic [7:0] eng_status;
    logic [7:0] eng_rdata;

    logic       resp_done;
    logic       stray_done;
    assign eng_done = resp_done | stray_done;

    logic [7:0] st_arr [0:15];
    int         st_len;
    logic [7:0] rd_val;
    logic [2:0] cmds [$];
    int         cyc;
    int         checks;
    int         errors;

    flash_prog_sequencer #(
        .EN_CYCLES(EN_CYC),
        .POLL_GAP (GAP),
        .POLL_MAX (PMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .verify      (verify),
        .wr_byte     (wr_byte),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .eng_enable  (eng_enable),
        .eng_controll(eng_controll),
        .eng_wdata   (eng_wdata),
        .eng_done    (eng_done),
        .eng_status  (eng_status),
        .eng_rdata   (eng_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: commands the sequence must issue and the final outcome (0 = done).
    function automatic void model(input bit v, input logic [7:0] b, input logic [7:0] sts[$],
                                  input logic [7:0] rdv, output logic [2:0] ops[$],
                                  output logic [1:0] code);
        logic [7:0] s;
        ops = {};
        ops.push_back(OP_WRITE_CMD);
        ops.push_back(OP_RD_STATUS);
        s = sts[0];
        if (!s[1]) begin
            code = 2'b01;
            return;
        end
        ops.push_back(OP_WR_DATA);
        for (int p = 1; p <= int'(PMAX); p++) begin
            ops.push_back(OP_RD_STATUS);
            s = sts[(p < sts.size()) ? p : sts.size() - 1];
            if (!s[0]) begin
                if (v) begin
                    ops.push_back(OP_RD_DATA);
                    code = (rdv == b) ? 2'b00 : 2'b11;
                end else begin
                    code = 2'b00;
                end
                return;
            end
        end
        code = 2'b10;
    endfunction

    // Engine model: answers each command a random latency after enable drops.
    initial begin
        int         idx;
        int         lat;
        bit         pend;
        bit         en_prev;
        logic [2:0] op;
        resp_done  = 1'b0;
        eng_status = 8'h00;
        eng_rdata  = 8'h00;
        idx = 0; lat = 0; pend = 1'b0; en_prev = 1'b0; op = 3'b000;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (!busy) idx = 0;
            if (rst) begin
                pend = 1'b0;
            end else if (eng_enable && !en_prev) begin
                pend = 1'b1;
                op   = eng_controll;
                lat  = int'($urandom_range(0, 3));
            end else if (pend && !eng_enable) begin
                if (lat == 0) begin
                    resp_done = 1'b1;
                    pend      = 1'b0;
                    if (op == OP_RD_STATUS) begin
                        eng_status = st_arr[(idx < st_len) ? idx : st_len - 1];
                        idx++;
                    end else begin
                        eng_status = 8'($urandom);
                    end
                    eng_rdata = (op == OP_RD_DATA) ? rd_val : 8'($urandom);
                end else begin
                    lat--;
                end
            end
            en_prev = eng_enable;
        end
    end

    // Command monitor: logs issued opcodes, strobe width and issue latency.
    initial begin
        bit         en_p;
        int         hi_len;
        int         last_done;
        logic [2:0] last_op;
        int         exp_lat;
        en_p = 1'b0; hi_len = 0; last_done = -1; last_op = 3'b000; cyc = 0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (eng_enable && !en_p) begin
                if (last_done >= 0) begin
                    exp_lat = (eng_controll == OP_RD_STATUS && last_op == OP_RD_STATUS)
                              ? int'(GAP) + 1 : 1;
                    check_eq("issue_latency", 32'(cyc - last_done), 32'(exp_lat));
                end
                cmds.push_back(eng_controll);
                last_op = eng_controll;
                hi_len  = 1;
            end else if (eng_enable) begin
                hi_len++;
            end else if (en_p) begin
                check_eq("enable_width", 32'(hi_len), 32'(EN_CYC));
            end
            if (resp_done && busy) last_done = cyc;
            if (!busy) last_done = -1;
            en_p = eng_enable;
        end
    end

    task automatic run_txn(input bit v, input logic [7:0] b, input logic [7:0] sts[$],
                           input logic [7:0] rdv, input bit extra_start, input bit stray);
        logic [2:0] eq[$];
        logic [1:0] ecode;
        int         base;
        bit         fin;
        int         pulses;
        model(v, b, sts, rdv, eq, ecode);
        for (int i = 0; i < sts.size(); i++) st_arr[i] = sts[i];
        st_len = sts.size();
        rd_val = rdv;
        @(negedge clk);
        base    = cmds.size();
        start   = 1'b1;
        verify  = v;
        wr_byte = b;
        @(negedge clk);
        start   = 1'b0;
        verify  = 1'($urandom);
        wr_byte = 8'($urandom);
        @(posedge clk);
        #3;
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_enable", 32'(eng_enable), 32'd1);
        check_eq("start_opcode", 32'(eng_controll), 32'(OP_WRITE_CMD));
        check_eq("start_wdata", 32'(eng_wdata), 32'(b));
        fin = 1'b0;
        for (int k = 1; k < 2000; k++) begin
            stray_done = (stray && k == 1);
            start      = (extra_start && k == 3);
            wr_byte    = 8'($urandom);
            @(posedge clk);
            #3;
            if (done || error) begin
                fin = 1'b1;
                break;
            end
        end
        stray_done = 1'b0;
        start      = 1'b0;
        check_eq("txn_complete", 32'(fin), 32'd1);
        check_eq("result_done", 32'(done), 32'(ecode == 2'b00));
        check_eq("result_error", 32'(error), 32'(ecode != 2'b00));
        if (ecode != 2'b00) check_eq("err_code", 32'(err_code), 32'(ecode));
        check_eq("busy_at_end", 32'(busy), 32'd0);
        check_eq("wdata_held", 32'(eng_wdata), 32'(b));
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #3;
            pulses += int'(done) + int'(error);
            if (ecode != 2'b00 && k == 0) check_eq("err_code_held", 32'(err_code), 32'(ecode));
        end
        check_eq("single_pulse", 32'(pulses), 32'd0);
        check_eq("cmd_count", 32'(cmds.size() - base), 32'(eq.size()));
        for (int i = 0; i < eq.size() && base + i < cmds.size(); i++)
            check_eq("cmd_opcode", 32'(cmds[base + i]), 32'(eq[i]));
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] b;
        logic [7:0] rd;
        int         nb;
        int         base;
        int         pulses;
        bit         hit;
        checks = 0; errors = 0;
        stray_done = 1'b0;
        st_len = 1; st_arr[0] = 8'h00; rd_val = 8'h00;

        // Reset held with start asserted: nothing may happen.
        rst = 1'b1; start = 1'b1; verify = 1'b1; wr_byte = 8'hFF;
        repeat (4) @(posedge clk);
        #3;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_enable", 32'(eng_enable), 32'd0);
        check_eq("rst_opcode", 32'(eng_controll), 32'd0);
        check_eq("rst_err_code", 32'(err_code), 32'd0);
        check_eq("rst_wdata", 32'(eng_wdata), 32'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        check_eq("post_rst_no_cmd", 32'(cmds.size()), 32'd0);

        // Directed scenarios.
        q = '{8'h02, 8'h03, 8'h03, 8'h00};
        run_txn(1'b0, 8'hA5, q, 8'h00, 1'b1, 1'b1);
        q = '{8'h00};
        run_txn(1'b0, 8'h5A, q, 8'h00, 1'b0, 1'b0);
        q = '{8'h02, 8'h01};
        run_txn(1'b0, 8'h11, q, 8'h00, 1'b0, 1'b1);
        q = '{8'h02, 8'h00};
        run_txn(1'b1, 8'h3C, q, 8'h3C, 1'b0, 1'b0);
        run_txn(1'b1, 8'h3C, q, 8'h3D, 1'b1, 1'b0);

        // Randomized transactions.
        for (int t = 0; t < 24; t++) begin
            q = {};
            b = 8'($urandom);
            q.push_back(($urandom_range(0, 7) != 0) ? (8'($urandom) | 8'h02) : (8'($urandom) & 8'hFD));
            nb = int'($urandom_range(0, 4));
            for (int i = 0; i < nb; i++) q.push_back(8'($urandom) | 8'h01);
            q.push_back(8'($urandom) & 8'hFE);
            rd = ($urandom_range(0, 2) == 0) ? (b ^ 8'($urandom_range(1, 255))) : b;
            run_txn(1'($urandom), b, q, rd, 1'($urandom), 1'($urandom));
        end

        // Reset while polling aborts without a pulse.
        st_arr[0] = 8'h02; st_arr[1] = 8'h01; st_len = 2;
        @(negedge clk);
        base = cmds.size();
        start = 1'b1; verify = 1'b0; wr_byte = 8'h77;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            #3;
            if (cmds.size() - base >= 5 && !eng_enable && eng_controll == OP_RD_STATUS) begin
                hit = 1'b1;
                break;
            end
        end
        check_eq("reached_poll_wait", 32'(hit), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #3;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_enable", 32'(eng_enable), 32'd0);
        check_eq("abort_opcode", 32'(eng_controll), 32'd0);
        pulses = int'(done) + int'(error);
        @(negedge clk);
        rst = 1'b0;
        base = cmds.size();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #3;
            pulses += int'(done) + int'(error);
        end
        check_eq("abort_no_pulse", 32'(pulses), 32'd0);
        check_eq("abort_no_cmd", 32'(cmds.size() - base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_prog_sequencer.md
# flash_prog_sequencer

Sequences the SPI flash command engine through a complete single-byte program: write-enable, status check, data write, busy polling and optional read-back verify. Sits between the user logic and the SPI command engine. It drives the engine's `enable`/`controll` command pair and consumes the engine's completion and data returns. A single `start` pulse replaces the hand-ordered command stream the engine otherwise needs.

## Interface
Parameters:
- `EN_CYCLES`, default 4: cycles `eng_enable` is held high per command (1..15).
- `POLL_GAP`, default 16: idle cycles between consecutive status polls (1..255).
- `POLL_MAX`, default 1000: maximum status polls before timeout (1..65535).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  one-cycle request; accepted only when `busy`=0.
- `verify`  in  1  sampled with `start`; 1 = read back and compare.
- `wr_byte`  in  8  data byte, sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`/`error`.
- `done`  out  1  one-cycle success pulse.
- `error`  out  1  one-cycle failure pulse.
- `err_code`  out  2  01 WEL not set, 10 poll timeout, 11 verify mismatch; valid with `error`, held until next `start`.
- `eng_enable`  out  1  command strobe to the engine.
- `eng_controll`  out  3  engine command: 000 IDLE, 001 WRITE_CMD, 010 RD_STATUS, 011 WR_DATA, 100 RD_DATA.
- `eng_wdata`  out  8  latched `wr_byte`, stable while `busy`.
- `eng_done`  in  1  one-cycle pulse: engine finished the current command.
- `eng_status`  in  8  status register, valid with `eng_done` after RD_STATUS (bit0 WIP, bit1 WEL).
- `eng_rdata`  in  8  read byte, valid with `eng_done` after RD_DATA.

## Operation
- Command sequence: WRITE_CMD, then RD_STATUS (WEL check), then WR_DATA, then repeated RD_STATUS polling, then RD_DATA (only if verify), then finish.
- Each command has an ISSUE phase and a WAIT phase:
  - ISSUE: `eng_controll` = opcode and `eng_enable`=1 for exactly EN_CYCLES cycles.
  - WAIT: `eng_enable`=0, `eng_controll` holds the opcode until `eng_done`.
- States: IDLE, WREN_ISS, WREN_WT, CHK_ISS, CHK_WT, PROG_ISS, PROG_WT, POLL_ISS, POLL_WT, GAP, READ_ISS, READ_WT, FIN.
- Transitions:
  - IDLE: on `start`, latch `verify`/`wr_byte`, clear `err_code`, go to WREN_ISS.
  - WREN_WT: on `eng_done`, go to CHK_ISS.
  - CHK_WT: on `eng_done`, if `eng_status[1]`=1 go to PROG_ISS; else error 01.
  - PROG_WT: on `eng_done`, clear the poll counter and go to POLL_ISS.
  - POLL_WT: on `eng_done`, increment the poll counter, then:
    - if `eng_status[0]`=0, go to READ_ISS when verify=1, else FIN;
    - else if the count equals POLL_MAX, error 10;
    - else go to GAP.
  - GAP: wait POLL_GAP cycles, then go to POLL_ISS.
  - READ_WT: on `eng_done`, if `eng_rdata`==`eng_wdata` go to FIN; else error 11.
  - FIN or error: pulse `done` or `error` for one cycle, return to IDLE, `busy`=0.
- `eng_done` is honoured only in *_WT states. A pulse arriving in any other state is ignored.
- `start` while `busy`=1 is ignored; no queueing.
- Poll counter: 16 bits, no wrap, because POLL_MAX ≤ 65535.

## Timing
- Reset values: state IDLE; `busy`, `done`, `error`, `eng_enable` = 0; `err_code`, `eng_controll` = 000-equivalent (00/000); `eng_wdata` = 0x00.
- `rst` asserted mid-operation aborts the sequence. All outputs take reset values at the next rising edge, with no `done`/`error` pulse.
- `start` sampled at edge N: at edge N+1, `busy`=1, `eng_enable`=1 and `eng_controll`=001.
- `eng_enable` falls at edge N+1+EN_CYCLES.
- `eng_done` at edge M in a *_WT state: the next command's ISSUE begins at M+1.
- After a GAP, the next poll issues POLL_GAP+1 edges after the POLL_WT `eng_done`.
- `done`/`error` assert at the edge after the decisive `eng_done`. `busy` falls at that same edge.
- Minimum full sequence with no verify and one poll: 4×(EN_CYCLES+engine latency)+2 cycles.
- `eng_controll` returns to 000 in IDLE.

## Test plan
- Reset with `start` held high: all outputs 0, no command issued until `rst` falls and a fresh `start` arrives.
- Happy path: `verify`=0, `wr_byte`=0xA5; engine returns WEL status 0x02, then 0x03 twice, then 0x00.
  - Commands issued in order 001, 010, 011, 010, 010, 010, each with `eng_enable` high exactly 4 cycles.
  - `done` pulses once; `busy` falls the same cycle.
- WEL missing: first status 0x00 → `error` with `err_code`=01; no WR_DATA issued.
- Timeout: POLL_MAX=3, status stuck at 0x01 → exactly 3 RD_STATUS polls after WR_DATA, each spaced POLL_GAP idle cycles, then `err_code`=10.
- Verify: `verify`=1, `wr_byte`=0x3C.
  - `eng_rdata`=0x3C → `done`.
  - Rerun with `eng_rdata`=0x3D → `err_code`=11.
- Robustness:
  - `start` during `busy` → ignored.
  - Stray `eng_done` during an ISSUE phase → ignored.
  - `rst` during POLL_WT → IDLE next cycle, `eng_enable`=0, no pulse.
